// File: rtl/uart_core.sv
// -----------------------------------------------------------------------------
// uart_core
// Single-clock UART: an 8-bit (PKT_SIZE) serial receiver and transmitter, each
// buffered by its own FIFO. The host pops received packets and pushes packets
// for transmission with a req/ready/done handshake. Bit timing is a fixed
// divide of the system clock (CLKS_PER_BIT clocks per serial bit).
//
// Frame: start (0), PKT_SIZE data bits MSB first, [even parity], stop (1).
// Optional feature macro: UART_PARITY_EN -- when defined, an even-parity bit
// is inserted after the last data bit on TX and checked on RX. A frame that
// fails the parity check is discarded.
//
// Ports:
//   clock           in   system clock, rising edge
//   reset           in   asynchronous active-high reset
//   io_rx           in   serial input (idle high, asynchronous to clock)
//   io_tx           out  serial output (idle high, registered)
//   io_rxReq_pkt    out  packet popped from the RX FIFO (held until next pop)
//   io_rxReq_req    in   one-cycle pop request
//   io_rxReq_ready  out  RX FIFO non-empty
//   io_rxReq_done   out  one-cycle pulse when a pop completes
//   io_txReq_pkt    in   packet to transmit
//   io_txReq_req    in   one-cycle push request
//   io_txReq_ready  out  TX FIFO not full
//   io_txReq_done   out  one-cycle pulse when a push is accepted
// -----------------------------------------------------------------------------
module uart_core #(
    parameter int PKT_SIZE     = 8,
    parameter int CLKS_PER_BIT = 3,
    parameter int RX_DEPTH     = 32,
    parameter int TX_DEPTH     = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                io_rx,
    output logic                io_tx,
    output logic [PKT_SIZE-1:0] io_rxReq_pkt,
    input  logic                io_rxReq_req,
    output logic                io_rxReq_ready,
    output logic                io_rxReq_done,
    input  logic [PKT_SIZE-1:0] io_txReq_pkt,
    input  logic                io_txReq_req,
    output logic                io_txReq_ready,
    output logic                io_txReq_done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
    localparam int IDX_W = $clog2(PKT_SIZE) + 1;
    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam int TX_AW = $clog2(TX_DEPTH);

    localparam logic [CNT_W-1:0] C_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] C_HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    // The TX stop bit leaves one clock early so the IDLE cycle completes it;
    // back-to-back frames then keep the stop bit exactly CLKS_PER_BIT long.
    localparam logic [CNT_W-1:0] C_STOP_LAST = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [IDX_W-1:0] C_IDX_LAST  = IDX_W'(PKT_SIZE - 1);
    localparam logic [RX_AW:0]   C_RX_FULL   = (RX_AW + 1)'(RX_DEPTH);
    localparam logic [TX_AW:0]   C_TX_FULL   = (TX_AW + 1)'(TX_DEPTH);

    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_PAR   = 3'd3,
        RX_STOP  = 3'd4
    } rx_state_t;

    typedef enum logic [2:0] {
        TX_IDLE  = 3'd0,
        TX_START = 3'd1,
        TX_DATA  = 3'd2,
        TX_PAR   = 3'd3,
        TX_STOP  = 3'd4
    } tx_state_t;

    // Even parity: the parity bit makes the total count of ones even.
    function automatic logic f_even_parity(input logic [PKT_SIZE-1:0] data);
        f_even_parity = ^data;
    endfunction

    // ------------------------------------------------------------------ RX --
    logic                r_rx_meta;
    logic                r_rx_sync;
    logic                r_rx_prev;
    rx_state_t           r_rx_state;
    logic [CNT_W-1:0]    r_rx_cnt;
    logic [IDX_W-1:0]    r_rx_idx;
    logic [PKT_SIZE-1:0] r_rx_shift;
    logic                r_rx_par_err;
    logic                r_rx_push;

    logic [PKT_SIZE-1:0] r_rx_mem [RX_DEPTH];
    logic [RX_AW-1:0]    r_rx_wptr;
    logic [RX_AW-1:0]    r_rx_rptr;
    logic [RX_AW:0]      r_rx_count;
    logic [RX_AW:0]      w_rx_count_nxt;
    logic                w_rx_wr;
    logic                w_rx_rd;

    // Two-flop synchroniser plus a history flop for falling-edge detection
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= io_rx;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    // RX frame sequencer: start qualification, mid-bit sampling, stop check
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rx_state   <= RX_IDLE;
            r_rx_cnt     <= '0;
            r_rx_idx     <= '0;
            r_rx_shift   <= '0;
            r_rx_par_err <= 1'b0;
            r_rx_push    <= 1'b0;
        end else begin
            r_rx_push <= 1'b0;
            case (r_rx_state)
                RX_IDLE: begin
                    if (r_rx_prev && !r_rx_sync) begin
                        r_rx_state <= RX_START;
                        r_rx_cnt   <= '0;
                    end else begin
                        r_rx_cnt   <= '0;
                    end
                end
                RX_START: begin
                    if (r_rx_cnt == C_HALF_LAST) begin
                        r_rx_cnt <= '0;
                        // A start bit that is high again by mid-bit is a glitch.
                        if (!r_rx_sync) begin
                            r_rx_state   <= RX_DATA;
                            r_rx_idx     <= '0;
                            r_rx_par_err <= 1'b0;
                        end else begin
                            r_rx_state <= RX_IDLE;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt + CNT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (r_rx_cnt == C_BIT_LAST) begin
                        r_rx_cnt   <= '0;
                        r_rx_shift <= {r_rx_shift[PKT_SIZE-2:0], r_rx_sync};
                        if (r_rx_idx == C_IDX_LAST) begin
`ifdef UART_PARITY_EN
                            r_rx_state <= RX_PAR;
`else
                            r_rx_state <= RX_STOP;
`endif
                        end else begin
                            r_rx_idx <= r_rx_idx + IDX_W'(1);
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt + CNT_W'(1);
                    end
                end
                RX_PAR: begin
                    if (r_rx_cnt == C_BIT_LAST) begin
                        r_rx_cnt     <= '0;
                        r_rx_par_err <= (r_rx_sync != f_even_parity(r_rx_shift));
                        r_rx_state   <= RX_STOP;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + CNT_W'(1);
                    end
                end
                RX_STOP: begin
                    if (r_rx_cnt == C_BIT_LAST) begin
                        r_rx_cnt   <= '0;
                        r_rx_state <= RX_IDLE;
                        // Framing or parity errors drop the packet silently.
                        r_rx_push  <= r_rx_sync & ~r_rx_par_err;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_rx_state <= RX_IDLE;
                    r_rx_cnt   <= '0;
                end
            endcase
        end
    end

    // A packet arriving at a full FIFO is dropped; contents stay untouched.
    assign w_rx_wr = r_rx_push && (r_rx_count != C_RX_FULL);
    assign w_rx_rd = io_rxReq_req && io_rxReq_ready;

    // RX occupancy update for simultaneous push/pop
    always_comb begin
        w_rx_count_nxt = r_rx_count;
        if (w_rx_wr && !w_rx_rd) begin
            w_rx_count_nxt = r_rx_count + (RX_AW + 1)'(1);
        end else if (!w_rx_wr && w_rx_rd) begin
            w_rx_count_nxt = r_rx_count - (RX_AW + 1)'(1);
        end else begin
            w_rx_count_nxt = r_rx_count;
        end
    end

    // RX FIFO storage (no reset: flushing is done through the pointers)
    always_ff @(posedge clock) begin
        if (w_rx_wr) begin
            r_rx_mem[r_rx_wptr] <= r_rx_shift;
        end
    end

    // RX FIFO pointers, occupancy and registered host pop port
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rx_wptr      <= '0;
            r_rx_rptr      <= '0;
            r_rx_count     <= '0;
            io_rxReq_ready <= 1'b0;
            io_rxReq_pkt   <= '0;
            io_rxReq_done  <= 1'b0;
        end else begin
            if (w_rx_wr) begin
                r_rx_wptr <= r_rx_wptr + RX_AW'(1);
            end
            if (w_rx_rd) begin
                io_rxReq_pkt <= r_rx_mem[r_rx_rptr];
                r_rx_rptr    <= r_rx_rptr + RX_AW'(1);
            end
            io_rxReq_done  <= w_rx_rd;
            r_rx_count     <= w_rx_count_nxt;
            io_rxReq_ready <= (w_rx_count_nxt != '0);
        end
    end

    // ------------------------------------------------------------------ TX --
    logic [PKT_SIZE-1:0] r_tx_mem [TX_DEPTH];
    logic [TX_AW-1:0]    r_tx_wptr;
    logic [TX_AW-1:0]    r_tx_rptr;
    logic [TX_AW:0]      r_tx_count;
    logic [TX_AW:0]      w_tx_count_nxt;
    logic                w_tx_wr;
    logic                w_tx_rd;
    logic [PKT_SIZE-1:0] w_tx_head;

    tx_state_t           r_tx_state;
    logic [CNT_W-1:0]    r_tx_cnt;
    logic [IDX_W-1:0]    r_tx_idx;
    logic [PKT_SIZE-1:0] r_tx_shift;
    logic                r_tx_par;

    assign w_tx_wr   = io_txReq_req && io_txReq_ready;
    assign w_tx_rd   = (r_tx_state == TX_IDLE) && (r_tx_count != '0);
    assign w_tx_head = r_tx_mem[r_tx_rptr];

    // TX occupancy update for simultaneous push/pop
    always_comb begin
        w_tx_count_nxt = r_tx_count;
        if (w_tx_wr && !w_tx_rd) begin
            w_tx_count_nxt = r_tx_count + (TX_AW + 1)'(1);
        end else if (!w_tx_wr && w_tx_rd) begin
            w_tx_count_nxt = r_tx_count - (TX_AW + 1)'(1);
        end else begin
            w_tx_count_nxt = r_tx_count;
        end
    end

    // TX FIFO storage (no reset: flushing is done through the pointers)
    always_ff @(posedge clock) begin
        if (w_tx_wr) begin
            r_tx_mem[r_tx_wptr] <= io_txReq_pkt;
        end
    end

    // TX FIFO pointers, occupancy and registered host push handshake
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_tx_wptr      <= '0;
            r_tx_rptr      <= '0;
            r_tx_count     <= '0;
            io_txReq_ready <= 1'b1;
            io_txReq_done  <= 1'b0;
        end else begin
            if (w_tx_wr) begin
                r_tx_wptr <= r_tx_wptr + TX_AW'(1);
            end
            if (w_tx_rd) begin
                r_tx_rptr <= r_tx_rptr + TX_AW'(1);
            end
            io_txReq_done  <= w_tx_wr;
            r_tx_count     <= w_tx_count_nxt;
            io_txReq_ready <= (w_tx_count_nxt != C_TX_FULL);
        end
    end

    // TX frame sequencer driving the registered serial line
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_idx   <= '0;
            r_tx_shift <= '0;
            r_tx_par   <= 1'b0;
            io_tx      <= 1'b1;
        end else begin
            case (r_tx_state)
                TX_IDLE: begin
                    r_tx_cnt <= '0;
                    if (w_tx_rd) begin
                        r_tx_shift <= w_tx_head;
                        r_tx_par   <= f_even_parity(w_tx_head);
                        io_tx      <= 1'b0;
                        r_tx_state <= TX_START;
                    end else begin
                        io_tx <= 1'b1;
                    end
                end
                TX_START: begin
                    if (r_tx_cnt == C_BIT_LAST) begin
                        r_tx_cnt   <= '0;
                        r_tx_idx   <= '0;
                        io_tx      <= r_tx_shift[PKT_SIZE-1];
                        r_tx_shift <= {r_tx_shift[PKT_SIZE-2:0], 1'b0};
                        r_tx_state <= TX_DATA;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + CNT_W'(1);
                    end
                end
                TX_DATA: begin
                    if (r_tx_cnt == C_BIT_LAST) begin
                        r_tx_cnt <= '0;
                        if (r_tx_idx == C_IDX_LAST) begin
`ifdef UART_PARITY_EN
                            io_tx      <= r_tx_par;
                            r_tx_state <= TX_PAR;
`else
                            io_tx      <= 1'b1;
                            r_tx_state <= TX_STOP;
`endif
                        end else begin
                            r_tx_idx   <= r_tx_idx + IDX_W'(1);
                            io_tx      <= r_tx_shift[PKT_SIZE-1];
                            r_tx_shift <= {r_tx_shift[PKT_SIZE-2:0], 1'b0};
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt + CNT_W'(1);
                    end
                end
                TX_PAR: begin
                    if (r_tx_cnt == C_BIT_LAST) begin
                        r_tx_cnt   <= '0;
                        io_tx      <= 1'b1;
                        r_tx_state <= TX_STOP;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + CNT_W'(1);
                    end
                end
                TX_STOP: begin
                    if (r_tx_cnt == C_STOP_LAST) begin
                        r_tx_cnt   <= '0;
                        r_tx_state <= TX_IDLE;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_tx_state <= TX_IDLE;
                    r_tx_cnt   <= '0;
                    io_tx      <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_core.sv
// -----------------------------------------------------------------------------
// tb_uart_core
// Randomised self-checking bench for uart_core. A queue-based reference model
// tracks what each FIFO must hold; a line decoder rebuilds TX frames from
// io_tx by bit timing alone and compares them against push order.
// -----------------------------------------------------------------------------
module tb_uart_core;

    localparam int PKT      = 8;
    localparam int CPB      = 3;
    localparam int RX_DEPTH = 32;
    localparam int TX_DEPTH = 32;

    logic           clock;
    logic           reset;
    logic           io_rx;
    logic           io_tx;
    logic [PKT-1:0] io_rxReq_pkt;
    logic           io_rxReq_req;
    logic           io_rxReq_ready;
    logic           io_rxReq_done;
    logic [PKT-1:0] io_txReq_pkt;
    logic           io_txReq_req;
    logic           io_txReq_ready;
    logic           io_txReq_done;

    uart_core #(
        .PKT_SIZE    (PKT),
        .CLKS_PER_BIT(CPB),
        .RX_DEPTH    (RX_DEPTH),
        .TX_DEPTH    (TX_DEPTH)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .io_rx         (io_rx),
        .io_tx         (io_tx),
        .io_rxReq_pkt  (io_rxReq_pkt),
        .io_rxReq_req  (io_rxReq_req),
        .io_rxReq_ready(io_rxReq_ready),
        .io_rxReq_done (io_rxReq_done),
        .io_txReq_pkt  (io_txReq_pkt),
        .io_txReq_req  (io_txReq_req),
        .io_txReq_ready(io_txReq_ready),
        .io_txReq_done (io_txReq_done)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int             n_checks = 0;
    int             n_errors = 0;

    // Reference model state
    logic [PKT-1:0] rx_q[$];
    logic [PKT-1:0] exp_tx[$];
    logic [PKT-1:0] last_pkt = '0;
    int             tx_acc = 0;
    int             tx_started = 0;
    int             tx_decoded = 0;
    logic           mon_en = 1'b1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance n clocks; returns 1 time unit after a falling edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clock);
            #1;
        end
    endtask

    // Drive one serial frame onto io_rx; stop_bit=0 forces a framing error.
    task automatic send_frame(input logic [PKT-1:0] d, input logic stop_bit);
        io_rx = 1'b0;
        tick(CPB);
        for (int i = PKT - 1; i >= 0; i--) begin
            io_rx = d[i];
            tick(CPB);
        end
`ifdef UART_PARITY_EN
        io_rx = ^d;
        tick(CPB);
`endif
        io_rx = stop_bit;
        tick(CPB);
        io_rx = 1'b1;
    endtask

    // One host pop; expectation comes from the model queue.
    task automatic rx_pop();
        logic exp_rdy;
        exp_rdy = (rx_q.size() != 0);
        check_eq("rx_ready", io_rxReq_ready, exp_rdy);
        io_rxReq_req = 1'b1;
        tick(1);
        io_rxReq_req = 1'b0;
        check_eq("rx_done", io_rxReq_done, exp_rdy);
        if (exp_rdy) begin
            last_pkt = rx_q.pop_front();
        end
        check_eq("rx_pkt", io_rxReq_pkt, last_pkt);
        tick(1);
        check_eq("rx_done_low", io_rxReq_done, 1'b0);
    endtask

    // One host push; acceptance expected while model occupancy is below depth.
    task automatic tx_push(input logic [PKT-1:0] d);
        logic exp_rdy;
        exp_rdy = ((tx_acc - tx_started) < TX_DEPTH);
        check_eq("tx_ready", io_txReq_ready, exp_rdy);
        io_txReq_req = 1'b1;
        io_txReq_pkt = d;
        tick(1);
        io_txReq_req = 1'b0;
        check_eq("tx_done", io_txReq_done, exp_rdy);
        if (exp_rdy) begin
            tx_acc++;
            exp_tx.push_back(d);
        end
    endtask

    // Line decoder: find a start bit, sample every bit at its middle.
    initial begin
        logic [PKT-1:0] d;
        logic [31:0]    exp;
        forever begin
            @(negedge clock);
            if (mon_en && io_tx == 1'b0) begin
                tx_started++;
                @(negedge clock);
                check_eq("tx_start", io_tx, 1'b0);
                d = '0;
                for (int i = 0; i < PKT; i++) begin
                    repeat (CPB) @(negedge clock);
                    d = {d[PKT-2:0], io_tx};
                end
`ifdef UART_PARITY_EN
                repeat (CPB) @(negedge clock);
                check_eq("tx_par", io_tx, ^d);
`endif
                repeat (CPB) @(negedge clock);
                check_eq("tx_stop", io_tx, 1'b1);
                exp = (exp_tx.size() != 0) ? {24'h0, exp_tx.pop_front()} : 32'hFFFF_FFFF;
                check_eq("tx_order", d, exp);
                tx_decoded++;
            end
        end
    end

    initial begin
        logic [PKT-1:0] d;
        logic [11:0]    seq;
        int             nb;
        int             lows;
        logic           good;

        reset        = 1'b1;
        io_rx        = 1'b1;
        io_rxReq_req = 1'b0;
        io_txReq_req = 1'b0;
        io_txReq_pkt = '0;
        tick(5);
        reset = 1'b0;
        tick(1);
        check_eq("rst_tx", io_tx, 1'b1);
        check_eq("rst_rx_ready", io_rxReq_ready, 1'b0);
        check_eq("rst_tx_ready", io_txReq_ready, 1'b1);
        check_eq("rst_rx_done", io_rxReq_done, 1'b0);
        check_eq("rst_tx_done", io_txReq_done, 1'b0);
        check_eq("rst_rx_pkt", io_rxReq_pkt, 8'h00);

        // Back-to-back directed frames
        send_frame(8'hCD, 1'b1);
        rx_q.push_back(8'hCD);
        send_frame(8'hAA, 1'b1);
        rx_q.push_back(8'hAA);
        tick(10);
        rx_pop();
        rx_pop();
        check_eq("rx_empty", io_rxReq_ready, 1'b0);
        rx_pop();   // empty: no done, pkt held

        // Framing error and a one-cycle glitch: nothing enqueued
        send_frame(8'h5A, 1'b0);
        tick(8);
        io_rx = 1'b0;
        tick(1);
        io_rx = 1'b1;
        tick(12);
        check_eq("rx_bad_ready", io_rxReq_ready, 1'b0);

        // Random stream with occasional framing errors, overflowing the FIFO
        for (int k = 0; k < RX_DEPTH + 6; k++) begin
            d    = PKT'($urandom);
            good = ($urandom_range(0, 5) != 0);
            send_frame(d, good);
            if (good && rx_q.size() < RX_DEPTH) begin
                rx_q.push_back(d);
            end
            tick(good ? $urandom_range(0, 2) : 5);
        end
        tick(10);
        while (rx_q.size() != 0) begin
            rx_pop();
        end
        rx_pop();

        // Exact line waveform for 0x55
        d  = 8'h55;
        nb = 0;
        seq = '1;
        seq[nb] = 1'b0; nb++;
        for (int i = PKT - 1; i >= 0; i--) begin
            seq[nb] = d[i]; nb++;
        end
`ifdef UART_PARITY_EN
        seq[nb] = ^d; nb++;
`endif
        seq[nb] = 1'b1; nb++;
        tx_push(d);
        for (int k = 0; k < 10 && io_tx != 1'b0; k++) begin
            tick(1);
        end
        for (int s = 0; s < nb * CPB; s++) begin
            check_eq("tx55_bit", io_tx, seq[s / CPB]);
            tick(1);
        end
        for (int s = 0; s < 3; s++) begin
            check_eq("tx55_idle", io_tx, 1'b1);
            tick(1);
        end

        // Fill the TX FIFO every cycle until full, then one push that must be ignored
        for (int k = 0; k < 60 && (tx_acc - tx_started) < TX_DEPTH; k++) begin
            tx_push(PKT'($urandom));
        end
        check_eq("tx_full_occ", tx_acc - tx_started, TX_DEPTH);
        tx_push(8'hE7);
        for (int k = 0; k < 3000 && tx_decoded < tx_acc; k++) begin
            tick(1);
        end
        check_eq("tx_drain", tx_decoded, tx_acc);
        check_eq("tx_left", exp_tx.size(), 0);
        tick(5);

        // Reset during a TX frame
        mon_en = 1'b0;
        tx_push(8'h96);
        tx_push(8'h3C);
        tx_push(8'hF1);
        tick(8);
        reset = 1'b1;
        #1;
        check_eq("rst_mid_tx", io_tx, 1'b1);
        check_eq("rst_mid_txrdy", io_txReq_ready, 1'b1);
        tick(3);
        reset = 1'b0;
        tx_acc = 0;
        tx_started = 0;
        tx_decoded = 0;
        exp_tx.delete();
        lows = 0;
        for (int k = 0; k < 40; k++) begin
            tick(1);
            if (io_tx == 1'b0) lows++;
        end
        check_eq("tx_quiet", lows, 0);

        // Reset during an RX frame, with one packet already buffered
        send_frame(8'h3C, 1'b1);
        rx_q.push_back(8'h3C);
        tick(8);
        check_eq("rx_buf_ready", io_rxReq_ready, 1'b1);
        fork
            send_frame(8'hF0, 1'b1);
            begin
                tick(15);
                reset = 1'b1;
                #1;
                check_eq("rst_mid_rxrdy", io_rxReq_ready, 1'b0);
            end
        join
        tick(2);
        reset = 1'b0;
        rx_q.delete();
        last_pkt = '0;
        tick(12);
        check_eq("rx_flushed", io_rxReq_ready, 1'b0);
        rx_pop();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_core.md
Name: uart_core

Overview:
- Single-clock UART with independent 8-bit serial receiver and transmitter, each buffered by a FIFO.
- The host side uses a request/ready/done handshake to pop received packets and to push packets for transmission.
- Sits between the system-clock fabric and an external serial line.
- Bit timing is derived from the system clock via a fixed divider.

Parameters:
- PKT_SIZE, 8, data bits per frame.
- CLKS_PER_BIT, 3, system clocks per serial bit (>=2).
- RX_DEPTH, 32, RX FIFO entries (power of two).
- TX_DEPTH, 32, TX FIFO entries (power of two).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- io_rx  in  1  serial input; idles high; asynchronous to clock.
- io_tx  out  1  serial output; idles high.
- io_rxReq_pkt  out  PKT_SIZE  packet popped from the RX FIFO.
- io_rxReq_req  in  1  one-cycle request to pop the RX FIFO.
- io_rxReq_ready  out  1  RX FIFO non-empty.
- io_rxReq_done  out  1  one-cycle pulse when the pop completes.
- io_txReq_pkt  in  PKT_SIZE  packet to transmit.
- io_txReq_req  in  1  one-cycle request to push into the TX FIFO.
- io_txReq_ready  out  1  TX FIFO not full.
- io_txReq_done  out  1  one-cycle pulse when the push is accepted.

Behaviour:
- Reset values:
  - Both FIFOs empty; RX and TX FSMs IDLE.
  - io_tx=1, io_rxReq_pkt=0, both done signals=0.
  - io_rxReq_ready=0, io_txReq_ready=1.
- Frame format: start bit 0, PKT_SIZE data bits MSB first, stop bit 1. Each bit lasts CLKS_PER_BIT clocks. No parity.
- Input synchronisation: io_rx passes through a 2-flop synchroniser before any use.
- RX FSM states and transitions:
  - IDLE -> START on a synchronised falling edge of io_rx.
  - START: sample at CLKS_PER_BIT/2 (integer division). If 0, go to DATA; if 1, treat as a glitch and return to IDLE.
  - DATA: sample every CLKS_PER_BIT clocks; shift each sampled bit in at the LSB (MSB arrives first).
  - STOP: sample one bit period later. If 1, push the packet into the RX FIFO. If 0 (framing error), discard the packet. Either way return to IDLE.
  - If the RX FIFO is full at push time, drop the new packet; FIFO contents are unchanged.
  - RX returns to IDLE right after the stop sample, ready for back-to-back frames.
- RX host side:
  - io_rxReq_req sampled high while ready=1: pop the head. io_rxReq_pkt is registered with it on the next edge, and io_rxReq_done is high for exactly that following cycle.
  - io_rxReq_pkt holds its value until the next pop.
  - A request while empty is ignored: no done pulse, pkt unchanged.
- TX host side:
  - io_txReq_req sampled high while ready=1: push io_txReq_pkt. io_txReq_done pulses one cycle after the sampling edge.
  - A request while full is ignored: no done pulse.
- TX FSM:
  - In IDLE with the FIFO non-empty: pop the head and drive start, data (MSB first), then stop.
  - Each bit is held exactly CLKS_PER_BIT clocks; io_tx is registered.
  - After the stop bit: return to IDLE; the next frame may start on the following cycle.
- Simultaneous events: a push and a pop on the same FIFO in the same cycle are both performed; the occupancy count is unchanged.
- Asynchronous reset mid-frame: aborts the frame, flushes both FIFOs, forces io_tx=1.

Optional Feature:
- Macro: UART_PARITY_EN.
- Defined:
  - An even-parity bit is inserted between the last data bit and the stop bit, on both TX and RX.
  - RX discards a frame on parity mismatch, in addition to framing errors.
- Undefined: no parity bit; frame is 10 bits for PKT_SIZE=8.

Test Plan:
- Reset for 5 cycles -> io_tx=1, rxReq_ready=0, txReq_ready=1, both done=0.
- Inject 0xCD then 0xAA on io_rx at 3 clocks/bit, back-to-back. Wait for ready, pulse rxReq_req twice -> rxReq_pkt=0xCD then 0xAA, one done pulse each, ready=0 afterwards.
- Pulse txReq_req with 0x55 -> txReq_done pulse; io_tx sequence 0,0,1,0,1,0,1,0,1,1, each bit 3 cycles, then idle high.
- Inject a frame with stop bit 0, and separately a 1-cycle low glitch on io_rx -> nothing enqueued, rxReq_ready stays 0.
- Push 33 packets without draining -> first 32 get done pulses, ready drops at 32, 33rd ignored (no done). Transmitted order matches push order.
- Assert reset during a TX frame and during an RX frame -> io_tx=1 immediately, FIFOs empty, no partial packet delivered.
